iiitb_lifo_reverser: RTL and testbench

- Initiator-side controller for the 4-bit LIFO's push/pop interface (dataIn, dataOut, RW, EN, Rst, EMPTY, FULL).
- Accepts framed words on a valid/ready input stream and pushes them into the LIFO until end-of-frame.
- Then pops the whole frame and emits it word-reversed on a valid/ready output stream.
- Sits between a producer and consumer; the LIFO is instantiated beside it and wired to the lifo_* ports.

---
 rtl/iiitb_lifo_reverser_if.sv | 9 +
 rtl/iiitb_lifo_reverser.sv | 99 +++++++++
 tb/tb_iiitb_lifo_reverser.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/iiitb_lifo_reverser_if.sv
// iiitb_lifo_reverser_if: valid/ready word stream with an end-of-frame marker.
interface iiitb_lifo_reverser_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] data;
    logic valid;
    logic last;
    logic ready;
    modport master (output data, valid, last, input ready);
    modport slave (input data, valid, last, output ready);
endinterface

// File: rtl/iiitb_lifo_reverser.sv
// iiitb_lifo_reverser: buffers a framed stream in an external LIFO and replays it word-reversed.
// Define LIFO_REV_EMPTY_CHECK_EN to flag pops from an empty LIFO and first pushes into a non-empty one.
module iiitb_lifo_reverser #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CW = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    iiitb_lifo_reverser_if.slave src,
    iiitb_lifo_reverser_if.master dst,
    output logic [WIDTH-1:0] lifo_dataIn,
    output logic lifo_RW,
    output logic lifo_EN,
    output logic lifo_Rst,
    input  logic [WIDTH-1:0] lifo_dataOut,
    input  logic lifo_EMPTY,
    input  logic lifo_FULL,
    output logic err_ovf,
    output logic err_proto
);
    typedef enum logic [2:0] {INIT, FILL, DROP, DRAIN, WAIT, OUT} state_t;
    state_t state, nxt;
    logic [CW-1:0] count, count_d;
    logic [WIDTH-1:0] out_data_d, din_d;
    logic in_ready_d, out_valid_d, out_last_d, en_d, pop_d, ovf_d, proto_d;
    logic acc, push, popping, out_hs, full_hit;

    assign acc = src.valid & src.ready;
    assign push = acc & (state == FILL);
    assign popping = (state == DRAIN) & lifo_EN & lifo_RW;
    assign out_hs = (state == OUT) & dst.valid & dst.ready;
    assign full_hit = (count + 1'b1 == CW'(DEPTH)) | lifo_FULL;

    always_comb begin
        nxt = state;
        case (state)
            INIT: nxt = FILL;
            FILL: if (acc) nxt = src.last ? DRAIN : full_hit ? DROP : FILL;
            DROP: if (acc && src.last) nxt = DRAIN;
            DRAIN: if (popping) nxt = WAIT;
            WAIT: nxt = OUT;
            OUT: if (out_hs) nxt = (count == '0) ? FILL : DRAIN;
            default: nxt = INIT;
        endcase
    end

    // Pushes reach the LIFO one cycle after acceptance, so a DRAIN entered
    // straight from FILL first lets the final push land, then issues the pop.
    always_comb begin
        pop_d = (nxt == DRAIN) & ~push & ~popping;
        en_d = push | pop_d;
        din_d = push ? src.data : lifo_dataIn;
        in_ready_d = (nxt == FILL) | (nxt == DROP);
        count_d = push ? count + 1'b1 : popping ? count - 1'b1 : count;
        out_valid_d = (state == WAIT) | (dst.valid & ~out_hs);
        out_last_d = (state == WAIT) ? (count == '0) : (dst.last & ~out_hs);
        out_data_d = (state == WAIT) ? lifo_dataOut : dst.data;
        ovf_d = err_ovf | (push & ~src.last & full_hit);
    end

`ifdef LIFO_REV_EMPTY_CHECK_EN
    assign proto_d = err_proto | (popping & lifo_EMPTY) | (push & (count == '0) & ~lifo_EMPTY);
`else
    logic unused_empty;
    assign unused_empty = lifo_EMPTY;
    assign proto_d = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= INIT;
            count <= '0;
            src.ready <= 1'b0;
            dst.valid <= 1'b0;
            dst.last <= 1'b0;
            dst.data <= '0;
            lifo_EN <= 1'b0;
            lifo_RW <= 1'b0;
            lifo_dataIn <= '0;
            lifo_Rst <= 1'b1;
            err_ovf <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state <= nxt;
            count <= count_d;
            src.ready <= in_ready_d;
            dst.valid <= out_valid_d;
            dst.last <= out_last_d;
            dst.data <= out_data_d;
            lifo_EN <= en_d;
            lifo_RW <= pop_d;
            lifo_dataIn <= din_d;
            lifo_Rst <= 1'b0;
            err_ovf <= ovf_d;
            err_proto <= proto_d;
        end
    end
endmodule

// File: tb/tb_iiitb_lifo_reverser.sv
// tb_iiitb_lifo_reverser: directed frames against a behavioural LIFO, checked by an output scoreboard.
module tb_iiitb_lifo_reverser;
    logic Clk, Rst_n;
    logic [3:0] lifo_dataIn, lifo_dataOut;
    logic lifo_RW, lifo_EN, lifo_Rst, lifo_EMPTY, lifo_FULL, err_ovf, err_proto;
    logic force_empty;
    logic [3:0] mem [8];
    logic [3:0] sp;
    logic [4:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

`ifdef LIFO_REV_EMPTY_CHECK_EN
    localparam logic PROTO_EXP = 1'b1;
`else
    localparam logic PROTO_EXP = 1'b0;
`endif

    iiitb_lifo_reverser_if #(.WIDTH(4)) src_if ();
    iiitb_lifo_reverser_if #(.WIDTH(4)) dst_if ();

    iiitb_lifo_reverser #(.WIDTH(4), .DEPTH(8), .CW(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .src(src_if), .dst(dst_if),
        .lifo_dataIn(lifo_dataIn), .lifo_RW(lifo_RW), .lifo_EN(lifo_EN), .lifo_Rst(lifo_Rst),
        .lifo_dataOut(lifo_dataOut), .lifo_EMPTY(lifo_EMPTY), .lifo_FULL(lifo_FULL),
        .err_ovf(err_ovf), .err_proto(err_proto)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (lifo_Rst) begin
            sp <= 4'd0;
            lifo_dataOut <= 4'd0;
        end else if (lifo_EN) begin
            if (!lifo_RW && sp < 4'd8) begin
                mem[sp[2:0]] <= lifo_dataIn;
                sp <= sp + 4'd1;
            end else if (lifo_RW && sp > 4'd0) begin
                lifo_dataOut <= mem[3'(sp - 4'd1)];
                sp <= sp - 4'd1;
            end
        end
    end
    assign lifo_EMPTY = force_empty | (sp == 4'd0);
    assign lifo_FULL = (sp == 4'd8);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n && dst_if.valid) begin
            if (dst_if.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious output: got %0h with nothing expected", dst_if.data);
                end else begin
                    check("out_data", 8'(dst_if.data), 8'(exp_q[0][3:0]));
                    check("out_last", 8'(dst_if.last), 8'(exp_q[0][4]));
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                check("stalled out_data", 8'(dst_if.data), 8'(exp_q[0][3:0]));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic l);
        logic r;
        int n = 0;
        src_if.data = d;
        src_if.valid = 1'b1;
        src_if.last = l;
        do begin
            r = src_if.ready;
            @(negedge Clk);
            n++;
        end while (!r && n < 100);
        if (!r) begin
            vectors++;
            miscompares++;
            $display("FAIL send timeout: in_ready stayed 0 for word %0h", d);
        end
        src_if.valid = 1'b0;
        src_if.last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d outputs still missing", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic release_reset;
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        Rst_n = 1'b1;
        force_empty = 1'b0;
        src_if.valid = 1'b0;
        src_if.last = 1'b0;
        src_if.data = 4'd0;
        dst_if.ready = 1'b0;
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset in_ready", 8'(src_if.ready), 8'd0);
        check("reset out_valid", 8'(dst_if.valid), 8'd0);
        check("reset out_last", 8'(dst_if.last), 8'd0);
        check("reset out_data", 8'(dst_if.data), 8'd0);
        check("reset lifo_EN/RW", {6'd0, lifo_EN, lifo_RW}, 8'd0);
        check("reset lifo_dataIn", 8'(lifo_dataIn), 8'd0);
        check("reset lifo_Rst", 8'(lifo_Rst), 8'd1);
        check("reset errors", {6'd0, err_ovf, err_proto}, 8'd0);
        release_reset();
        check("init lifo_Rst", 8'(lifo_Rst), 8'd1);
        check("init in_ready", 8'(src_if.ready), 8'd0);
        @(negedge Clk);
        check("fill lifo_Rst", 8'(lifo_Rst), 8'd0);
        check("fill in_ready", 8'(src_if.ready), 8'd1);
        check("fill lifo_EN", 8'(lifo_EN), 8'd0);
        @(posedge Clk);
        #1 dst_if.ready = 1'b1;
        @(negedge Clk);

        exp_q = '{5'h06, 5'h04, 5'h02, 5'h10};
        for (int i = 0; i < 4; i++) send(4'(2 * i), i == 3);
        wait_idle("frame 0,2,4,6");
        check("err_ovf after 4-word frame", 8'(err_ovf), 8'd0);

        exp_q = '{5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A, 5'h09, 5'h18};
        for (int i = 0; i < 8; i++) send(4'(8 + i), i == 7);
        wait_idle("exact-depth frame");
        check("err_ovf after DEPTH-word frame", 8'(err_ovf), 8'd0);

        exp_q = '{5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h10};
        for (int i = 0; i < 10; i++) send(4'(i), i == 9);
        wait_idle("overflow frame");
        check("err_ovf after 10-word frame", 8'(err_ovf), 8'd1);

        @(posedge Clk);
        #1 dst_if.ready = 1'b0;
        @(negedge Clk);
        exp_q = '{5'h09, 5'h05, 5'h13};
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd9, 1'b1);
        for (int n = 0; n < 50 && !dst_if.valid; n++) @(negedge Clk);
        repeat (5) @(negedge Clk);
        check("stall out_valid", 8'(dst_if.valid), 8'd1);
        check("stall out_data", 8'(dst_if.data), 8'd9);
        @(posedge Clk);
        #1 dst_if.ready = 1'b1;
        wait_idle("stalled frame 3,5,9");

        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("mid-frame reset out_valid", 8'(dst_if.valid), 8'd0);
        release_reset();
        check("err_ovf cleared by reset", 8'(err_ovf), 8'd0);
        exp_q = '{5'h17};
        send(4'd7, 1'b1);
        wait_idle("single-word frame after reset");

        check("err_proto before empty test", 8'(err_proto), 8'd0);
        exp_q = '{5'h0B, 5'h1A};
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        force_empty = 1'b1;
        wait_idle("frame A,B with EMPTY forced");
        force_empty = 1'b0;
        check("err_proto after forced empty", 8'(err_proto), 8'(PROTO_EXP));
        check("scoreboard empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
